uart_led_cmd_ctrl: RTL and testbench

Command parser and configuration controller for the UART-driven LED pattern generator. Takes received bytes from the UART receiver and decodes fixed-format command frames. On each valid frame it atomically updates the 8-bit LED pattern (`Ctrl`) and the 32-bit per-bit step time (`Time`) that drive the LED sequencer. Malformed, stale or illegal frames are dropped, and the last good configuration is retained.

---
 rtl/uart_led_cmd_pkg.sv | 29 ++
 rtl/uart_led_cmd_ctrl_timer.sv | 34 +++
 rtl/uart_led_cmd_ctrl.sv | 124 ++++++++++++
 tb/tb_uart_led_cmd_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_led_cmd_pkg.sv
// Shared types and constants for the UART LED command parser.
// The checksum frame variant is selected by UART_LED_CMD_CHECKSUM_EN.
package uart_led_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_T3,
        ST_T2,
        ST_T1,
        ST_T0,
        ST_CT,
        ST_CS,
        ST_TL
    } state_e;

    localparam int FRAME_LEN_BASE = 8;
    localparam int FRAME_LEN_CSUM = 9;

    localparam logic [7:0] HDR0_DEF = 8'h55;
    localparam logic [7:0] HDR1_DEF = 8'hA5;
    localparam logic [7:0] TAIL_DEF = 8'hF0;

    // Modulo-256 sum of the four time bytes and the ctrl byte.
    function automatic logic [7:0] frame_csum(input logic [31:0] t, input logic [7:0] c);
        return t[31:24] + t[23:16] + t[15:8] + t[7:0] + c;
    endfunction

endpackage

// File: rtl/uart_led_cmd_ctrl_timer.sv
// Inter-byte gap timer: counts while a frame is in progress, cleared by each byte.
// expire is a single-cycle pulse when the gap reaches TIMEOUT_CYCLES-1.
module byte_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic run,
    input  logic kick,
    output logic expire
);

    localparam logic [31:0] LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] cnt_q, cnt_d;

    // A byte arriving on the expiry cycle suppresses the expiry.
    always_comb begin
        expire = run && !kick && (cnt_q == LAST);
        cnt_d  = cnt_q + 32'd1;
        if (!run || kick || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// Frame decoder for the UART LED sequencer: updates Ctrl/Time atomically on good frames.
// Define UART_LED_CMD_CHECKSUM_EN to require a CSUM byte before the tail.
module uart_led_cmd_ctrl
    import uart_led_cmd_pkg::*;
#(
    parameter logic [7:0]  HDR0           = HDR0_DEF,
    parameter logic [7:0]  HDR1           = HDR1_DEF,
    parameter logic [7:0]  TAIL           = TAIL_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter logic [7:0]  CTRL_RST       = 8'h00,
    parameter logic [31:0] TIME_RST       = 32'd500
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  Rx_data,
    input  logic        Rx_done,
    output logic [7:0]  Ctrl,
    output logic [31:0] Time,
    output logic        Cfg_valid,
    output logic        Frame_err
);

    state_e      state_q, state_d;
    logic [31:0] sh_time_q, sh_time_d;
    logic [7:0]  sh_ctrl_q, sh_ctrl_d;
    logic [31:0] time_q, time_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic        cfg_valid_q, cfg_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        expire;

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .run    (state_q != ST_IDLE),
        .kick   (Rx_done),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        sh_time_d   = sh_time_q;
        sh_ctrl_d   = sh_ctrl_q;
        time_d      = time_q;
        ctrl_d      = ctrl_q;
        cfg_valid_d = 1'b0;
        frame_err_d = 1'b0;
        if (Rx_done) begin
            case (state_q)
                ST_IDLE: if (Rx_data == HDR0) state_d = ST_HDR;
                ST_HDR: begin
                    if (Rx_data == HDR1)      state_d = ST_T3;
                    else if (Rx_data == HDR0) state_d = ST_HDR;
                    else                      state_d = ST_IDLE;
                end
                ST_T3: begin sh_time_d[31:24] = Rx_data; state_d = ST_T2; end
                ST_T2: begin sh_time_d[23:16] = Rx_data; state_d = ST_T1; end
                ST_T1: begin sh_time_d[15:8]  = Rx_data; state_d = ST_T0; end
                ST_T0: begin sh_time_d[7:0]   = Rx_data; state_d = ST_CT; end
                ST_CT: begin
                    sh_ctrl_d = Rx_data;
`ifdef UART_LED_CMD_CHECKSUM_EN
                    state_d   = ST_CS;
`else
                    state_d   = ST_TL;
`endif
                end
`ifdef UART_LED_CMD_CHECKSUM_EN
                ST_CS: begin
                    if (Rx_data == frame_csum(sh_time_q, sh_ctrl_q)) begin
                        state_d = ST_TL;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                    end
                end
`endif
                ST_TL: begin
                    state_d = ST_IDLE;
                    // Time==0 would underflow the sequencer's Time-1 compare.
                    if (Rx_data == TAIL && sh_time_q != 32'd0) begin
                        time_d      = sh_time_q;
                        ctrl_d      = sh_ctrl_q;
                        cfg_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (expire) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            sh_time_q   <= '0;
            sh_ctrl_q   <= '0;
            time_q      <= TIME_RST;
            ctrl_q      <= CTRL_RST;
            cfg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_time_q   <= sh_time_d;
            sh_ctrl_q   <= sh_ctrl_d;
            time_q      <= time_d;
            ctrl_q      <= ctrl_d;
            cfg_valid_q <= cfg_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign Ctrl      = ctrl_q;
    assign Time      = time_q;
    assign Cfg_valid = cfg_valid_q;
    assign Frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// Bench for uart_led_cmd_ctrl: directed frames plus random traffic against a byte-queue model.
// Honours UART_LED_CMD_CHECKSUM_EN for the frame layout.
module tb_uart_led_cmd_ctrl;

    localparam int TO = 100;
`ifdef UART_LED_CMD_CHECKSUM_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [7:0]  Rx_data;
    logic        Rx_done;
    logic [7:0]  Ctrl;
    logic [31:0] Time;
    logic        Cfg_valid;
    logic        Frame_err;

    always #5 Clk = ~Clk;

    uart_led_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Rx_data  (Rx_data),
        .Rx_done  (Rx_done),
        .Ctrl     (Ctrl),
        .Time     (Time),
        .Cfg_valid(Cfg_valid),
        .Frame_err(Frame_err)
    );

    int checks = 0;
    int errors = 0;
    int cfg_cnt = 0;
    int err_cnt = 0;

    // Reference model: bytes of the frame in progress plus idle-gap length.
    logic [7:0]  q[$];
    int          gap;
    logic [7:0]  exp_ctrl;
    logic [31:0] exp_time;
    logic        exp_cfg, exp_err;
    logic [31:0] mt;
    logic [7:0]  msum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task model_step(input logic d, input logic [7:0] b);
        exp_cfg = 1'b0;
        exp_err = 1'b0;
        if (!Reset_n) begin
            q.delete();
            gap      = 0;
            exp_ctrl = 8'h00;
            exp_time = 32'd500;
        end else if (d) begin
            gap = 0;
            if (q.size() == 0) begin
                if (b == 8'h55) q.push_back(b);
            end else if (q.size() == 1) begin
                if (b == 8'hA5)      q.push_back(b);
                else if (b != 8'h55) q.delete();
            end else begin
                q.push_back(b);
                mt   = {q[2], q[3], q[4], q[5]};
                msum = 8'((int'(q[2]) + int'(q[3]) + int'(q[4]) + int'(q[5]) + int'(q[6])) % 256);
                if (FLEN == 9 && q.size() == 8 && q[7] != msum) begin
                    exp_err = 1'b1;
                    q.delete();
                end else if (q.size() == FLEN) begin
                    if (b == 8'hF0 && mt != 0) begin
                        exp_cfg  = 1'b1;
                        exp_time = mt;
                        exp_ctrl = q[6];
                    end else begin
                        exp_err = 1'b1;
                    end
                    q.delete();
                end
            end
        end else if (q.size() != 0) begin
            gap++;
            if (gap >= TO) begin
                exp_err = 1'b1;
                q.delete();
                gap = 0;
            end
        end
    endtask

    task step(input logic d, input logic [7:0] b);
        Rx_done = d;
        Rx_data = b;
        @(posedge Clk);
        model_step(d, b);
        @(negedge Clk);
        chk("ctrl", {24'd0, Ctrl}, {24'd0, exp_ctrl});
        chk("time", Time, exp_time);
        chk("cfg_valid", {31'd0, Cfg_valid}, {31'd0, exp_cfg});
        chk("frame_err", {31'd0, Frame_err}, {31'd0, exp_err});
        cfg_cnt += int'(Cfg_valid);
        err_cnt += int'(Frame_err);
    endtask

    task idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task send(input logic [7:0] b, input int gmax);
        step(1'b1, b);
        if (gmax > 0) idle($urandom_range(0, gmax));
    endtask

    task send_frame(input logic [31:0] t, input logic [7:0] c, input logic [7:0] tail,
                    input int gmax, input bit bad_cs);
        logic [7:0] cs;
        cs = t[31:24] + t[23:16] + t[15:8] + t[7:0] + c;
        if (bad_cs) cs = cs ^ 8'h01;
        send(8'h55, gmax);
        send(8'hA5, gmax);
        send(t[31:24], gmax);
        send(t[23:16], gmax);
        send(t[15:8], gmax);
        send(t[7:0], gmax);
        send(c, gmax);
        if (FLEN == 9) send(cs, gmax);
        send(tail, 0);
    endtask

    initial begin
        logic [31:0] rt;
        Reset_n = 1'b0;
        Rx_done = 1'b0;
        Rx_data = 8'h00;
        exp_ctrl = 8'h00;
        exp_time = 32'd500;
        gap = 0;
        @(negedge Clk);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        Reset_n = 1'b1;
        idle(5);
        chk("rst_ctrl", {24'd0, Ctrl}, 32'h00);
        chk("rst_time", Time, 32'd500);
        chk("rst_pulses", cfg_cnt + err_cnt, 0);

        send_frame(32'd500, 8'hA5, 8'hF0, 0, 1'b0);
        chk("f1_cfg_cnt", cfg_cnt, 1);
        chk("f1_time", Time, 32'd500);
        chk("f1_ctrl", {24'd0, Ctrl}, 32'hA5);
        idle(2);

        send(8'h55, 0);
        send_frame(32'd100, 8'h3C, 8'hF0, 0, 1'b0);
        chk("resync_cfg_cnt", cfg_cnt, 2);
        chk("resync_time", Time, 32'd100);
        chk("resync_ctrl", {24'd0, Ctrl}, 32'h3C);

        send_frame(32'h0000_1234, 8'h77, 8'hF1, 1, 1'b0);
        send_frame(32'd0, 8'h11, 8'hF0, 1, 1'b0);
        idle(1);
        chk("bad_err_cnt", err_cnt, 2);
        chk("bad_time", Time, 32'd100);
        chk("bad_ctrl", {24'd0, Ctrl}, 32'h3C);

        send(8'h55, 0);
        send(8'hA5, 0);
        send(8'h00, 0);
        idle(TO - 1);
        chk("to_not_early", err_cnt, 2);
        idle(1);
        chk("to_err_cnt", err_cnt, 3);
        send_frame(32'h0001_0000, 8'h5A, 8'hF0, 0, 1'b0);
        chk("to_after_cfg_cnt", cfg_cnt, 3);
        chk("to_after_time", Time, 32'h0001_0000);

        send(8'h55, 0);
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        Reset_n = 1'b0;
        step(1'b0, 8'h00);
        Reset_n = 1'b1;
        chk("midrst_ctrl", {24'd0, Ctrl}, 32'h00);
        chk("midrst_time", Time, 32'd500);
        send(8'h01, 0);
        send(8'hF4, 0);
        send(8'hA5, 0);
        send(8'hF0, 0);
        idle(1);
        chk("midrst_no_commit", cfg_cnt, 3);
        chk("midrst_time2", Time, 32'd500);

        if (FLEN == 9) begin
            send_frame(32'd500, 8'hA5, 8'hF0, 0, 1'b1);
            idle(1);
            chk("csum_bad_err_cnt", err_cnt, 4);
        end

        for (int i = 0; i < 300; i++) begin
            rt = $urandom();
            case ($urandom_range(0, 5))
                0, 1: send_frame((rt == 0) ? 32'd1 : rt, 8'($urandom()), 8'hF0,
                                 $urandom_range(0, 2), $urandom_range(0, 7) == 0);
                2:    send_frame(rt | 32'd1, 8'($urandom()), 8'($urandom_range(0, 255)) | 8'h01, 1, 1'b0);
                3:    send_frame(32'd0, 8'($urandom()), 8'hF0, 1, 1'b0);
                4:    repeat ($urandom_range(1, 4)) send(8'($urandom()), 1);
                default: begin
                    send(8'h55, 0);
                    send(8'hA5, 0);
                    repeat ($urandom_range(0, 4)) send(8'($urandom()), 0);
                    idle($urandom_range(TO - 5, TO + 10));
                end
            endcase
            idle($urandom_range(0, 3));
        end
        idle(TO + 5);
        chk("final_ctrl", {24'd0, Ctrl}, {24'd0, exp_ctrl});
        chk("final_time", Time, exp_time);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
